// File: rtl/bin_to_bcd_pkg.sv
// Shared types and sizing helpers for the
// serial binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digits needed for 2^w-1.
  function automatic int bcd_digits(input int w);
    longint v;
    int     n;
    v = (longint'(1) << w) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n = n + 1;
    end
    return n;
  endfunction

  // Significant BCD bits needed for 2^w-1.
  function automatic int bcd_bits(input int w);
    longint v;
    int     n;
    v = (longint'(1) << w) - 1;
    n = 0;
    while (v >= 10) begin
      v = v / 10;
      n = n + 1;
    end
    return 4 * n + $clog2(int'(v) + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble cell: add 3 to a
// BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd.sv
// Serial shift-and-add-3 binary-to-BCD
// converter, one bit per clock.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W = 4,
  parameter int BCD_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [BIN_W-1:0] bin,
  output logic             in_ready,
  output logic             out_valid,
  output logic [BCD_W-1:0] bcd
);

  localparam int ND = bcd_digits(BIN_W);
  localparam int DW = 4 * ND;
  localparam int SW = DW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);

  if (BCD_W < bcd_bits(BIN_W)) begin : g_chk
    $error("BCD_W too narrow for BIN_W");
  end

  state_t           st;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    dig;
  logic [DW-1:0]    adj;
  logic [BIN_W-1:0] sh;
  logic [SW-1:0]    nxt;
  logic [DW-1:0]    nd;
  logic [BCD_W-1:0] res;
  logic [BCD_W-1:0] bcd_q;
  logic             last;

  for (genvar i = 0; i < ND; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (dig[4*i +: 4]),
      .q (adj[4*i +: 4])
    );
  end

  assign nxt  = {adj, sh} << 1;
  assign nd   = nxt[SW-1:BIN_W];
  assign last = (st == SHIFT) &&
                (cnt == CW'(BIN_W - 1));

  // Upper digit bits are always zero here.
  if (BCD_W < DW) begin : g_trunc
    assign res = nd[BCD_W-1:0];
    logic unused_hi;
    assign unused_hi = ^nd[DW-1:BCD_W];
  end else if (BCD_W == DW) begin : g_same
    assign res = nd;
  end else begin : g_pad
    assign res = {{(BCD_W-DW){1'b0}}, nd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      cnt   <= '0;
      dig   <= '0;
      sh    <= '0;
      bcd_q <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            st  <= SHIFT;
            cnt <= '0;
            dig <= '0;
            sh  <= bin;
          end
        end
        SHIFT: begin
          dig <= nd;
          sh  <= nxt[BIN_W-1:0];
          cnt <= cnt + CW'(1);
          if (last) begin
            st    <= DONE;
            bcd_q <= res;
          end
        end
        DONE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: a 4-bit
// directed instance and an 8-bit sweep.
module tb_bin_to_bcd;

  typedef struct {
    logic [9:0] exp;
    int         acc;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_na, rst_nb;
  logic       va, ra, ova;
  logic [3:0] ba;
  logic [4:0] bcda;
  logic       vb, rb, ovb;
  logic [7:0] bb;
  logic [9:0] bcdb;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_acc = 0;
  item_t qa[$];
  item_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd #(.BIN_W(4), .BCD_W(5)) u_a (
    .clk       (clk),
    .rst_n     (rst_na),
    .in_valid  (va),
    .bin       (ba),
    .in_ready  (ra),
    .out_valid (ova),
    .bcd       (bcda)
  );

  bin_to_bcd #(.BIN_W(8), .BCD_W(10)) u_b (
    .clk       (clk),
    .rst_n     (rst_nb),
    .in_valid  (vb),
    .bin       (bb),
    .in_ready  (rb),
    .out_valid (ovb),
    .bcd       (bcdb)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [9:0] dec(int v);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    return 10'((h << 8) | (t << 4) | u);
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    item_t it;
    if (rst_na && ova) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_extra got=%0h", bcda);
      end else begin
        it = qa.pop_front();
        chk("a_bcd", 32'(bcda), 32'(it.exp));
        chk("a_lat", 32'(cyc - it.acc), 32'd4);
      end
    end
  end

  always @(negedge clk) begin
    item_t it;
    if (rst_nb && ovb) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_extra got=%0h", bcdb);
      end else begin
        it = qb.pop_front();
        chk("b_bcd", 32'(bcdb), 32'(it.exp));
        chk("b_lat", 32'(cyc - it.acc), 32'd8);
      end
    end
  end

  task automatic issue_a(input logic [3:0] v,
                         input logic [4:0] e,
                         input bit keep,
                         input bit push);
    int n = 0;
    @(negedge clk);
    va = 1'b1;
    ba = v;
    while (!ra && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ra) begin
      checks++;
      errors++;
      $display("FAIL a_ready_timeout got=0 want=1");
    end else begin
      last_acc = cyc + 1;
      if (push) qa.push_back('{10'(e), cyc + 1});
    end
    @(posedge clk);
    #1;
    if (!keep) va = 1'b0;
  endtask

  task automatic issue_b(input logic [7:0] v,
                         input bit keep);
    int n = 0;
    @(negedge clk);
    vb = 1'b1;
    bb = v;
    while (!rb && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rb) begin
      checks++;
      errors++;
      $display("FAIL b_ready_timeout got=0 want=1");
    end else begin
      qb.push_back('{dec(int'(v)), cyc + 1});
    end
    @(posedge clk);
    #1;
    if (!keep) vb = 1'b0;
  endtask

  task automatic drain(input bit a);
    int n = 0;
    while (n < 100 &&
           (a ? qa.size() : qb.size()) != 0) begin
      @(negedge clk);
      n++;
    end
    if ((a ? qa.size() : qb.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d want=0",
               a ? qa.size() : qb.size());
    end
  endtask

  initial begin
    int acc1;
    rst_na = 1'b0;
    rst_nb = 1'b0;
    va = 1'b0;
    vb = 1'b0;
    ba = '0;
    bb = '0;
    #12;
    chk("rst_a_ready", 32'(ra), 32'd1);
    chk("rst_a_valid", 32'(ova), 32'd0);
    chk("rst_a_bcd", 32'(bcda), 32'd0);
    chk("rst_b_ready", 32'(rb), 32'd1);
    chk("rst_b_valid", 32'(ovb), 32'd0);
    chk("rst_b_bcd", 32'(bcdb), 32'd0);
    @(negedge clk);
    rst_na = 1'b1;
    rst_nb = 1'b1;

    issue_a(4'd0, 5'h00, 0, 1);
    issue_a(4'd1, 5'h01, 0, 1);
    issue_a(4'd2, 5'h02, 0, 1);
    issue_a(4'd3, 5'h03, 0, 1);
    issue_a(4'd4, 5'h04, 0, 1);
    issue_a(4'd5, 5'h05, 0, 1);
    issue_a(4'd6, 5'h06, 0, 1);
    issue_a(4'd7, 5'h07, 0, 1);
    issue_a(4'd9, 5'h09, 0, 1);
    issue_a(4'd10, 5'h10, 0, 1);
    issue_a(4'd15, 5'h15, 0, 1);
    drain(1);

    // in_valid held high across two requests
    issue_a(4'd12, 5'h12, 1, 1);
    acc1 = last_acc;
    issue_a(4'd3, 5'h03, 0, 1);
    chk("b2b_gap", 32'(last_acc - acc1), 32'd6);
    drain(1);

    // bin changes and in_valid pulses mid-shift
    issue_a(4'd14, 5'h14, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_ready", 32'(ra), 32'd0);
      if (i == 0) begin
        ba = 4'd2;
        va = 1'b1;
      end
      if (i == 1) va = 1'b0;
    end
    drain(1);
    chk("hold_bcd", 32'(bcda), 32'h14);

    // reset mid-shift aborts the conversion
    issue_a(4'd6, 5'h06, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_na = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcda), 32'd0);
    chk("abort_ready", 32'(ra), 32'd1);
    chk("abort_valid", 32'(ova), 32'd0);
    @(negedge clk);
    rst_na = 1'b1;
    va = 1'b1;
    ba = 4'd11;
    qa.push_back('{10'h011, cyc + 1});
    @(posedge clk);
    #1;
    va = 1'b0;
    chk("first_accept", 32'(ra), 32'd0);
    drain(1);
    repeat (8) @(negedge clk);

    for (int v = 0; v < 256; v++)
      issue_b(8'(v), v != 255);
    drain(0);
    chk("b_max", 32'(bcdb), 32'h255);
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
